// File: rtl/operand_fwd_unit_if.sv
// Bus bundle for the ID-stage operand forwarding unit: read ports, pipeline
// writeback taps, mul/div issue/result and the stall/forwarding outputs.
interface operand_fwd_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NREAD  = 2,
    parameter int CNT_W  = 16
);
    logic [NREAD*REG_AW-1:0] rs_addr;
    logic [NREAD-1:0]        rs_used;
    logic [NREAD*DATA_W-1:0] rf_data;
    logic                    id_ex_wen;
    logic [REG_AW-1:0]       id_ex_waddr;
    logic                    id_ex_is_load;
    logic                    ex_mem_wen;
    logic [REG_AW-1:0]       ex_mem_waddr;
    logic [DATA_W-1:0]       ex_mem_wdata;
    logic                    mem_wb_wen;
    logic [REG_AW-1:0]       mem_wb_waddr;
    logic [DATA_W-1:0]       mem_wb_wdata;
    logic                    md_start;
    logic [REG_AW-1:0]       md_waddr;
    logic [DATA_W-1:0]       md_wdata;
    logic                    cnt_clr;
    logic [NREAD*DATA_W-1:0] opnd;
    logic [NREAD*2-1:0]      fwd_sel;
    logic                    stall;
    logic                    md_done;
    logic                    md_busy;
    logic [CNT_W-1:0]        stall_cnt;

    modport slave (
        input  rs_addr, rs_used, rf_data,
        input  id_ex_wen, id_ex_waddr, id_ex_is_load,
        input  ex_mem_wen, ex_mem_waddr, ex_mem_wdata,
        input  mem_wb_wen, mem_wb_waddr, mem_wb_wdata,
        input  md_start, md_waddr, md_wdata, cnt_clr,
        output opnd, fwd_sel, stall, md_done, md_busy, stall_cnt
    );

    modport master (
        output rs_addr, rs_used, rf_data,
        output id_ex_wen, id_ex_waddr, id_ex_is_load,
        output ex_mem_wen, ex_mem_waddr, ex_mem_wdata,
        output mem_wb_wen, mem_wb_waddr, mem_wb_wdata,
        output md_start, md_waddr, md_wdata, cnt_clr,
        input  opnd, fwd_sel, stall, md_done, md_busy, stall_cnt
    );
endinterface

// File: rtl/operand_fwd_unit.sv
// ID-stage operand forwarding and interlock for the MIPS pipeline: per-port
// bypass muxing, load-use / mul-div stalls, mul/div countdown FSM, stall counter.
module operand_fwd_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NREAD  = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_fwd_unit_if.slave bus
);
    localparam int MDC_W = $clog2(MD_LAT);
    localparam logic [MDC_W-1:0] MD_INIT = MDC_W'(MD_LAT - 1);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t         md_state;
    logic [MDC_W-1:0]  md_count;
    logic [REG_AW-1:0] md_dest;
    logic              md_done_r;
    logic              md_busy_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [NREAD-1:0]        lu_hit;
    logic [NREAD-1:0]        md_hit;
    logic [NREAD*DATA_W-1:0] opnd_w;
    logic [NREAD*2-1:0]      sel_w;
    logic                    load_use;
    logic                    md_pending;
    logic                    md_hazard;
    logic                    md_struct;
    logic                    stall_w;
    logic                    md_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Per-port bypass: mul/div result beats EX/MEM beats MEM/WB beats regfile.
    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [REG_AW-1:0] rs;
        logic              rs_nz;
        logic              hit_md;
        logic              hit_ex;
        logic              hit_wb;

        assign rs     = bus.rs_addr[i*REG_AW +: REG_AW];
        assign rs_nz  = |rs;
        assign hit_md = rs_nz && md_done_r && (md_dest == rs);
        assign hit_ex = rs_nz && bus.ex_mem_wen && (bus.ex_mem_waddr == rs);
        assign hit_wb = rs_nz && bus.mem_wb_wen && (bus.mem_wb_waddr == rs);

        assign sel_w[i*2 +: 2] = hit_md ? 2'b11 :
                                 hit_ex ? 2'b10 :
                                 hit_wb ? 2'b01 : 2'b00;
        assign opnd_w[i*DATA_W +: DATA_W] = hit_md ? bus.md_wdata   :
                                            hit_ex ? bus.ex_mem_wdata :
                                            hit_wb ? bus.mem_wb_wdata :
                                                     bus.rf_data[i*DATA_W +: DATA_W];

        assign lu_hit[i] = bus.rs_used[i] && rs_nz && (bus.id_ex_waddr == rs);
        assign md_hit[i] = bus.rs_used[i] && rs_nz && (md_dest == rs);
    end

    assign load_use   = bus.id_ex_is_load && bus.id_ex_wen && (|bus.id_ex_waddr) && (|lu_hit);
    // The DONE cycle forwards the result and frees the unit, so it never stalls.
    assign md_pending = md_busy_r && !md_done_r;
    assign md_hazard  = md_pending && (|md_hit);
    assign md_struct  = bus.md_start && md_pending;
    assign stall_w    = load_use || md_hazard || md_struct;
    assign md_accept  = bus.md_start && !stall_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state  <= MD_IDLE;
            md_count  <= '0;
            md_dest   <= '0;
            md_done_r <= 1'b0;
            md_busy_r <= 1'b0;
        end else begin
            md_done_r <= 1'b0;
            case (md_state)
                MD_IDLE, MD_DONE: begin
                    if (md_accept) begin
                        md_state  <= MD_BUSY;
                        md_count  <= MD_INIT;
                        md_dest   <= bus.md_waddr;
                        md_busy_r <= 1'b1;
                    end else begin
                        md_state  <= MD_IDLE;
                        md_busy_r <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    if (md_count == MDC_W'(1)) begin
                        md_state  <= MD_DONE;
                        md_count  <= '0;
                        md_done_r <= 1'b1;
                    end else begin
                        md_count <= md_count - MDC_W'(1);
                    end
                end
                default: begin
                    md_state  <= MD_IDLE;
                    md_busy_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_r <= '0;
        end else if (stall_w) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    assign bus.opnd      = opnd_w;
    assign bus.fwd_sel   = sel_w;
    assign bus.stall     = stall_w;
    assign bus.md_done   = md_done_r;
    assign bus.md_busy   = md_busy_r;
    assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: forwarding priority, zero register,
// load-use and mul/div interlocks, back-to-back mul/div, reset mid-op, counter saturation.
module tb_operand_fwd_unit;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREAD  = 2;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_fwd_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NREAD(NREAD), .CNT_W(CNT_W)) bus ();

    operand_fwd_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NREAD(NREAD), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs_addr       = '0;
        bus.rs_used       = '0;
        bus.rf_data       = '0;
        bus.id_ex_wen     = 1'b0;
        bus.id_ex_waddr   = '0;
        bus.id_ex_is_load = 1'b0;
        bus.ex_mem_wen    = 1'b0;
        bus.ex_mem_waddr  = '0;
        bus.ex_mem_wdata  = '0;
        bus.mem_wb_wen    = 1'b0;
        bus.mem_wb_waddr  = '0;
        bus.mem_wb_wdata  = '0;
        bus.md_start      = 1'b0;
        bus.md_waddr      = '0;
        bus.md_wdata      = '0;
        bus.cnt_clr       = 1'b0;
    endtask

    task automatic set_rs(input logic [REG_AW-1:0] a0, input logic [REG_AW-1:0] a1,
                          input logic [NREAD-1:0] used);
        bus.rs_addr = {a1, a0};
        bus.rs_used = used;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("rst_md_busy", 64'(bus.md_busy), 64'd0);
        check("rst_md_done", 64'(bus.md_done), 64'd0);
        check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        rst_n = 1'b1;

        // EX/MEM and MEM/WB both target r5: EX/MEM wins
        tick();
        set_rs(5'd5, 5'd0, 2'b01);
        bus.rf_data      = {32'h0, 32'hDEAD};
        bus.ex_mem_wen   = 1'b1; bus.ex_mem_waddr = 5'd5; bus.ex_mem_wdata = 32'h11;
        bus.mem_wb_wen   = 1'b1; bus.mem_wb_waddr = 5'd5; bus.mem_wb_wdata = 32'h22;
        settle();
        check("prio_opnd0", 64'(bus.opnd[31:0]), 64'h11);
        check("prio_sel0", 64'(bus.fwd_sel[1:0]), 64'h2);
        check("prio_stall", 64'(bus.stall), 64'd0);
        check("prio_sel1", 64'(bus.fwd_sel[3:2]), 64'h0);
        bus.ex_mem_wen = 1'b0;
        settle();
        check("wb_opnd0", 64'(bus.opnd[31:0]), 64'h22);
        check("wb_sel0", 64'(bus.fwd_sel[1:0]), 64'h1);
        bus.mem_wb_wen = 1'b0;
        settle();
        check("rf_opnd0", 64'(bus.opnd[31:0]), 64'hDEAD);

        // r0 is never forwarded even when a stage writes it
        tick();
        clear_inputs();
        set_rs(5'd0, 5'd0, 2'b11);
        bus.ex_mem_wen = 1'b1; bus.ex_mem_waddr = 5'd0; bus.ex_mem_wdata = 32'h55;
        settle();
        check("r0_opnd0", 64'(bus.opnd[31:0]), 64'h0);
        check("r0_sel0", 64'(bus.fwd_sel[1:0]), 64'h0);
        check("r0_stall", 64'(bus.stall), 64'd0);

        // Load-use on r8
        tick();
        clear_inputs();
        bus.id_ex_wen = 1'b1; bus.id_ex_waddr = 5'd8; bus.id_ex_is_load = 1'b1;
        set_rs(5'd8, 5'd8, 2'b00);
        settle();
        check("lu_unused_stall", 64'(bus.stall), 64'd0);
        set_rs(5'd8, 5'd8, 2'b11);
        settle();
        check("lu_stall", 64'(bus.stall), 64'd1);
        tick();
        clear_inputs();
        set_rs(5'd8, 5'd8, 2'b11);
        bus.mem_wb_wen = 1'b1; bus.mem_wb_waddr = 5'd8; bus.mem_wb_wdata = 32'h800;
        settle();
        check("lu_next_sel0", 64'(bus.fwd_sel[1:0]), 64'h1);
        check("lu_next_sel1", 64'(bus.fwd_sel[3:2]), 64'h1);
        check("lu_next_opnd1", 64'(bus.opnd[63:32]), 64'h800);
        check("lu_next_stall", 64'(bus.stall), 64'd0);
        check("lu_stall_cnt", 64'(bus.stall_cnt), 64'd1);

        tick();
        clear_inputs();
        bus.cnt_clr = 1'b1;

        // mul/div r3, consumer waits for md_done
        tick();
        clear_inputs();
        bus.md_start = 1'b1; bus.md_waddr = 5'd3;
        settle();
        check("md_t0_cnt", 64'(bus.stall_cnt), 64'd0);
        check("md_t0_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.md_start = 1'b0;
        set_rs(5'd3, 5'd0, 2'b01);
        settle();
        check("md_t1_busy", 64'(bus.md_busy), 64'd1);
        check("md_t1_done", 64'(bus.md_done), 64'd0);
        check("md_t1_stall", 64'(bus.stall), 64'd1);
        tick();
        check("md_t2_stall", 64'(bus.stall), 64'd1);
        tick();
        check("md_t3_stall", 64'(bus.stall), 64'd1);
        check("md_t3_done", 64'(bus.md_done), 64'd0);
        tick();
        bus.md_wdata = 32'hABCD;
        settle();
        check("md_t4_done", 64'(bus.md_done), 64'd1);
        check("md_t4_opnd0", 64'(bus.opnd[31:0]), 64'hABCD);
        check("md_t4_sel0", 64'(bus.fwd_sel[1:0]), 64'h3);
        check("md_t4_stall", 64'(bus.stall), 64'd0);
        check("md_t4_cnt", 64'(bus.stall_cnt), 64'd3);
        tick();
        clear_inputs();
        settle();
        check("md_t5_busy", 64'(bus.md_busy), 64'd0);
        check("md_t5_done", 64'(bus.md_done), 64'd0);

        // Structural stall while busy, then back-to-back restart in DONE
        tick();
        bus.md_start = 1'b1; bus.md_waddr = 5'd4;
        settle();
        check("b2b_t0_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.md_start = 1'b0;
        tick();
        bus.md_start = 1'b1; bus.md_waddr = 5'd6;
        settle();
        check("b2b_t2_struct", 64'(bus.stall), 64'd1);
        tick();
        bus.md_start = 1'b0;
        tick();
        bus.md_start = 1'b1; bus.md_waddr = 5'd6;
        settle();
        check("b2b_t4_done", 64'(bus.md_done), 64'd1);
        check("b2b_t4_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.md_start = 1'b0;
        settle();
        check("b2b_t5_busy", 64'(bus.md_busy), 64'd1);
        check("b2b_t5_done", 64'(bus.md_done), 64'd0);
        tick();
        tick();
        check("b2b_t7_done", 64'(bus.md_done), 64'd0);
        tick();
        set_rs(5'd0, 5'd6, 2'b10);
        bus.md_wdata = 32'h1234;
        settle();
        check("b2b_t8_done", 64'(bus.md_done), 64'd1);
        check("b2b_t8_opnd1", 64'(bus.opnd[63:32]), 64'h1234);
        check("b2b_t8_sel1", 64'(bus.fwd_sel[3:2]), 64'h3);
        tick();
        clear_inputs();
        settle();
        check("b2b_t9_busy", 64'(bus.md_busy), 64'd0);

        // Reset in the middle of an op
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        bus.md_start = 1'b1; bus.md_waddr = 5'd7;
        settle();
        check("rmo_t0_cnt", 64'(bus.stall_cnt), 64'd0);
        tick();
        bus.md_start = 1'b0;
        set_rs(5'd7, 5'd0, 2'b01);
        settle();
        check("rmo_t1_stall", 64'(bus.stall), 64'd1);
        tick();
        check("rmo_t2_cnt", 64'(bus.stall_cnt), 64'd1);
        check("rmo_t2_busy", 64'(bus.md_busy), 64'd1);
        rst_n = 1'b0;
        settle();
        check("rmo_rst_busy", 64'(bus.md_busy), 64'd0);
        check("rmo_rst_done", 64'(bus.md_done), 64'd0);
        check("rmo_rst_cnt", 64'(bus.stall_cnt), 64'd0);
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rmo_no_done_%0d", i), 64'(bus.md_done), 64'd0);
        end

        // md_waddr 0 runs the FSM but a used r0 read never stalls
        bus.md_start = 1'b1; bus.md_waddr = 5'd0;
        tick();
        bus.md_start = 1'b0;
        set_rs(5'd0, 5'd0, 2'b11);
        settle();
        check("mdr0_busy", 64'(bus.md_busy), 64'd1);
        check("mdr0_stall", 64'(bus.stall), 64'd0);
        repeat (4) tick();
        clear_inputs();

        // Saturation: 20 load-use stall cycles into a 4-bit counter
        bus.id_ex_wen = 1'b1; bus.id_ex_waddr = 5'd8; bus.id_ex_is_load = 1'b1;
        set_rs(5'd8, 5'd0, 2'b01);
        repeat (20) tick();
        check("sat_stall", 64'(bus.stall), 64'd1);
        check("sat_cnt", 64'(bus.stall_cnt), 64'd15);
        bus.cnt_clr = 1'b1;
        tick();
        check("clr_cnt", 64'(bus.stall_cnt), 64'd0);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
